mc_ctrl_fsm: RTL and testbench
==============================

# mc_ctrl_fsm

Multi-cycle MIPS control sequencer. It replaces the single-cycle decoder when the core moves to a shared-memory multi-cycle datapath. Each instruction runs as a sequence of states: fetch, decode, execute, memory, writeback. The block issues per-cycle mux selects, write enables and ALU control, and stalls on a memory ready handshake. It supports R-type (add/sub/and/or/slt), lw, sw, beq, addi and j, with the same opcode/funct and ALU-control encodings as the existing control unit.

## Interface
No parameters.
- clk  in  1  single clock, all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- opC  in  6  opcode from instruction register (IR[31:26]), stable after FETCH completes
- fnc  in  6  funct from instruction register (IR[5:0])
- mem_ready  in  1  memory completes current read/write this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if ALU zero
- iord  out  1  memory address select: 0 PC, 1 ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  instruction register load
- mem_to_reg  out  1  writeback data: 0 ALUOut, 1 MDR
- reg_dst  out  1  write register: 0 rt, 1 rd
- reg_write  out  1  register file write enable
- alu_src_a  out  1  0 PC, 1 reg A
- alu_src_b  out  2  00 reg B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
- pc_source  out  2  00 ALU result, 01 ALUOut, 10 jump target
- aluC  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
- state  out  4  current state code (debug)
- instr_done  out  1  one-cycle pulse on last cycle of each instruction
- illegal  out  1  one-cycle pulse, unsupported opcode in DECODE

## Operation
- State codes: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BEQ=8, JUMP=9, ADDIEX=10, ADDIWB=11. Codes 12–15 are unreachable and go to FETCH.
- Outputs are Moore-decoded from state. The only exceptions are the ir_write/pc_write gating by mem_ready in FETCH and the completion/decode pulses. Any output not listed for a state is 0.
- FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, aluC=010, pc_source=00; ir_write=pc_write=mem_ready. Stay in FETCH until mem_ready, then go to DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, aluC=010 (branch target into ALUOut). Next state by opC:
  - 000000 → EXEC
  - 100011 or 101011 → MEMADR
  - 000100 → BEQ
  - 001000 → ADDIEX
  - 000010 → JUMP
  - other → FETCH, with illegal=1 and instr_done=1
- MEMADR: alu_src_a=1, alu_src_b=10, aluC=010. Next state: MEMRD if opC=100011, else MEMWR.
- MEMRD: mem_read=1, iord=1. Hold until mem_ready, then go to MEMWB.
- MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1, instr_done=1. Next state FETCH.
- MEMWR: mem_write=1, iord=1. Hold until mem_ready; in that cycle instr_done=1 and next state FETCH.
- EXEC: alu_src_a=1, alu_src_b=00. aluC from fnc: 100000→010, 100010→110, 100100→000, 100101→001, 101010→111, other→000. Next state RWB.
- RWB: reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1. Next state FETCH.
- BEQ: alu_src_a=1, alu_src_b=00, aluC=110, pc_write_cond=1, pc_source=01, instr_done=1. Next state FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, aluC=010. Next state ADDIWB.
- ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0, instr_done=1. Next state FETCH.
- JUMP: pc_write=1, pc_source=10, instr_done=1. Next state FETCH.
- Unknown funct is not trapped: it executes as AND and writes back.

## Timing
- Reset: a cycle with rst=1 forces the next state to FETCH. During that cycle every output is forced to 0, including pc_write, ir_write, reg_write, mem_read, mem_write, instr_done and illegal, and state reads 0.
- Reset mid-operation (for example in MEMRD or MEMWR) abandons the instruction. No register or memory write occurs in the rst cycle or afterwards for that instruction.
- Cycle counts with zero wait (mem_ready tied 1), FETCH to instr_done inclusive:
  - lw 5
  - sw, R-type, addi 4
  - beq, j 3
  - illegal 2
- Each cycle of mem_ready=0 in FETCH, MEMRD or MEMWR adds exactly one cycle. Outputs stay constant while waiting, and ir_write/pc_write stay 0 in FETCH.
- mem_ready is ignored in all other states.
- instr_done and illegal are never high for more than one consecutive cycle.

## Test plan
- rst=1 for 2 cycles in state 6, then rst=0, mem_ready=1 → all outputs 0 during reset; first post-reset cycle has state=0, mem_read=1, ir_write=1, pc_write=1, aluC=010.
- R-type add (opC=000000, fnc=100000), mem_ready=1 → states 0,1,6,7,0; aluC=010 in EXEC; reg_write=reg_dst=1 and instr_done=1 in RWB only.
- lw (opC=100011) with mem_ready=0 for 3 cycles in MEMRD → states 0,1,2,3,3,3,3,4,0; mem_read=iord=1 held four cycles; reg_write and mem_to_reg=1 in state 4.
- sw (opC=101011), then beq (opC=000100), then j (opC=000010) back-to-back → sw 4 cycles with mem_write in state 5 only; beq 3 cycles, pc_write_cond=1, pc_source=01, aluC=110 in state 8; j 3 cycles, pc_write=1, pc_source=10.
- addi (opC=001000), then illegal opC=111111 → addi passes through states 10,11 with reg_dst=0, alu_src_b=10; illegal goes 0,1,0 with illegal=1 and instr_done=1 in DECODE and no write enables.
- FETCH with mem_ready=0 for 5 cycles → ir_write=pc_write=0 throughout, state stays 0; both go to 1 on the mem_ready=1 cycle.

Source files
------------

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS control sequencer: fetch/decode/execute/memory/writeback
// with Moore-decoded datapath controls and a memory-ready stall handshake.
module mc_ctrl_fsm (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opC,
  input  logic [5:0] fnc,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_source,
  output logic [2:0] aluC,
  output logic [3:0] state,
  output logic       instr_done,
  output logic       illegal
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BEQ    = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t state_q, state_d;

  // Unknown funct falls through to AND; it is deliberately not trapped.
  function automatic logic [2:0] funct_to_aluc(input logic [5:0] f);
    case (f)
      6'b100000: funct_to_aluc = ALU_ADD;
      6'b100010: funct_to_aluc = ALU_SUB;
      6'b100100: funct_to_aluc = ALU_AND;
      6'b100101: funct_to_aluc = ALU_OR;
      6'b101010: funct_to_aluc = ALU_SLT;
      default:   funct_to_aluc = ALU_AND;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d       = S_FETCH;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    pc_source     = 2'b00;
    aluC          = ALU_AND;
    instr_done    = 1'b0;
    illegal       = 1'b0;
    state         = 4'd0;

    // Reset masks every control so an abandoned instruction can never write.
    if (!rst) begin
      state = state_q;
      case (state_q)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          aluC      = ALU_ADD;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
          state_d   = mem_ready ? S_DECODE : S_FETCH;
        end
        S_DECODE: begin
          alu_src_b = 2'b11;
          aluC      = ALU_ADD;
          case (opC)
            OP_RTYPE:      state_d = S_EXEC;
            OP_LW, OP_SW:  state_d = S_MEMADR;
            OP_BEQ:        state_d = S_BEQ;
            OP_ADDI:       state_d = S_ADDIEX;
            OP_J:          state_d = S_JUMP;
            default: begin
              state_d    = S_FETCH;
              illegal    = 1'b1;
              instr_done = 1'b1;
            end
          endcase
        end
        S_MEMADR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          aluC      = ALU_ADD;
          state_d   = (opC == OP_LW) ? S_MEMRD : S_MEMWR;
        end
        S_MEMRD: begin
          mem_read = 1'b1;
          iord     = 1'b1;
          state_d  = mem_ready ? S_MEMWB : S_MEMRD;
        end
        S_MEMWB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
        S_MEMWR: begin
          mem_write  = 1'b1;
          iord       = 1'b1;
          instr_done = mem_ready;
          state_d    = mem_ready ? S_FETCH : S_MEMWR;
        end
        S_EXEC: begin
          alu_src_a = 1'b1;
          aluC      = funct_to_aluc(fnc);
          state_d   = S_RWB;
        end
        S_RWB: begin
          reg_write  = 1'b1;
          reg_dst    = 1'b1;
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
        S_BEQ: begin
          alu_src_a     = 1'b1;
          aluC          = ALU_SUB;
          pc_write_cond = 1'b1;
          pc_source     = 2'b01;
          instr_done    = 1'b1;
          state_d       = S_FETCH;
        end
        S_JUMP: begin
          pc_write   = 1'b1;
          pc_source  = 2'b10;
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
        S_ADDIEX: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          aluC      = ALU_ADD;
          state_d   = S_ADDIWB;
        end
        S_ADDIWB: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Scoreboard bench for mc_ctrl_fsm: stimulus queues per-cycle expected control
// vectors, a negedge monitor pops and compares them against the DUT outputs.
module tb_mc_ctrl_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opC = 6'd0;
  logic [5:0] fnc = 6'd0;
  logic       mem_ready = 1'b0;
  logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0] alu_src_b, pc_source;
  logic [2:0] aluC;
  logic [3:0] state;
  logic       instr_done, illegal;

  mc_ctrl_fsm dut (
    .clk(clk), .rst(rst), .opC(opC), .fnc(fnc), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_source(pc_source),
    .aluC(aluC), .state(state), .instr_done(instr_done), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // {pcw,pwc,iord,mrd,mwr,irw,m2r,rdst,rwr,asa,asb[2],psrc[2],aluC[3],state[4],done,ill}
  localparam logic [22:0] E_ZERO       = 23'd0;
  localparam logic [22:0] E_FETCH_RDY  = {1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,3'b010,4'd0,1'b0,1'b0};
  localparam logic [22:0] E_FETCH_WAIT = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,3'b010,4'd0,1'b0,1'b0};
  localparam logic [22:0] E_DECODE     = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,3'b010,4'd1,1'b0,1'b0};
  localparam logic [22:0] E_DEC_ILL    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,3'b010,4'd1,1'b1,1'b1};
  localparam logic [22:0] E_MEMADR     = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,3'b010,4'd2,1'b0,1'b0};
  localparam logic [22:0] E_MEMRD      = {1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,3'b000,4'd3,1'b0,1'b0};
  localparam logic [22:0] E_MEMWB      = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,2'b00,3'b000,4'd4,1'b1,1'b0};
  localparam logic [22:0] E_MEMWR_RDY  = {1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,3'b000,4'd5,1'b1,1'b0};
  localparam logic [22:0] E_MEMWR_WAIT = {1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,3'b000,4'd5,1'b0,1'b0};
  localparam logic [22:0] E_EXEC_ADD   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,3'b010,4'd6,1'b0,1'b0};
  localparam logic [22:0] E_EXEC_OR    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,3'b001,4'd6,1'b0,1'b0};
  localparam logic [22:0] E_EXEC_SLT   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,3'b111,4'd6,1'b0,1'b0};
  localparam logic [22:0] E_EXEC_UNK   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,3'b000,4'd6,1'b0,1'b0};
  localparam logic [22:0] E_RWB        = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'b00,2'b00,3'b000,4'd7,1'b1,1'b0};
  localparam logic [22:0] E_BEQ        = {1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01,3'b110,4'd8,1'b1,1'b0};
  localparam logic [22:0] E_JUMP       = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,3'b000,4'd9,1'b1,1'b0};
  localparam logic [22:0] E_ADDIEX     = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,3'b010,4'd10,1'b0,1'b0};
  localparam logic [22:0] E_ADDIWB     = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,2'b00,3'b000,4'd11,1'b1,1'b0};

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_BAD = 6'b111111;
  localparam logic [5:0] F_ADD = 6'b100000, F_OR = 6'b100101, F_SLT = 6'b101010;
  localparam logic [5:0] F_BAD = 6'b111111;

  typedef struct {
    logic [22:0] v;
    string       n;
  } exp_t;

  exp_t        sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [22:0] act;
  exp_t        cur;

  task automatic cyc(input logic r, input logic mr, input logic [5:0] op,
                     input logic [5:0] fn, input logic [22:0] ev, input string nm);
    exp_t t;
    @(posedge clk);
    #1;
    rst       = r;
    mem_ready = mr;
    opC       = op;
    fnc       = fn;
    t.v = ev;
    t.n = nm;
    sb.push_back(t);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      cur = sb.pop_front();
      act = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
             mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, pc_source,
             aluC, state, instr_done, illegal};
      n_tests++;
      if (act !== cur.v) begin
        n_fail++;
        $display("FAIL %s: got %06h expected %06h", cur.n, act, cur.v);
      end
    end
  end

  initial begin
    // Reset, then reach EXEC and reset twice from there
    cyc(1, 1, OP_R, F_ADD, E_ZERO,       "reset0");
    cyc(0, 1, OP_R, F_ADD, E_FETCH_RDY,  "pre_fetch");
    cyc(0, 1, OP_R, F_ADD, E_DECODE,     "pre_decode");
    cyc(1, 1, OP_R, F_ADD, E_ZERO,       "rst_in_exec");
    cyc(1, 1, OP_R, F_ADD, E_ZERO,       "rst_second");
    // R-type add
    cyc(0, 1, OP_R, F_ADD, E_FETCH_RDY,  "add_fetch");
    cyc(0, 1, OP_R, F_ADD, E_DECODE,     "add_decode");
    cyc(0, 1, OP_R, F_ADD, E_EXEC_ADD,   "add_exec");
    cyc(0, 1, OP_R, F_ADD, E_RWB,        "add_rwb");
    // lw with three wait cycles in MEMRD
    cyc(0, 1, OP_LW, F_ADD, E_FETCH_RDY, "lw_fetch");
    cyc(0, 1, OP_LW, F_ADD, E_DECODE,    "lw_decode");
    cyc(0, 1, OP_LW, F_ADD, E_MEMADR,    "lw_memadr");
    cyc(0, 0, OP_LW, F_ADD, E_MEMRD,     "lw_memrd_w1");
    cyc(0, 0, OP_LW, F_ADD, E_MEMRD,     "lw_memrd_w2");
    cyc(0, 0, OP_LW, F_ADD, E_MEMRD,     "lw_memrd_w3");
    cyc(0, 1, OP_LW, F_ADD, E_MEMRD,     "lw_memrd_rdy");
    cyc(0, 1, OP_LW, F_ADD, E_MEMWB,     "lw_memwb");
    // sw, beq, j back-to-back; mem_ready low in states that ignore it
    cyc(0, 1, OP_SW, F_ADD, E_FETCH_RDY, "sw_fetch");
    cyc(0, 1, OP_SW, F_ADD, E_DECODE,    "sw_decode");
    cyc(0, 1, OP_SW, F_ADD, E_MEMADR,    "sw_memadr");
    cyc(0, 1, OP_SW, F_ADD, E_MEMWR_RDY, "sw_memwr");
    cyc(0, 1, OP_BEQ, F_ADD, E_FETCH_RDY,"beq_fetch");
    cyc(0, 0, OP_BEQ, F_ADD, E_DECODE,   "beq_decode");
    cyc(0, 0, OP_BEQ, F_ADD, E_BEQ,      "beq_exec");
    cyc(0, 1, OP_J, F_ADD, E_FETCH_RDY,  "j_fetch");
    cyc(0, 0, OP_J, F_ADD, E_DECODE,     "j_decode");
    cyc(0, 0, OP_J, F_ADD, E_JUMP,       "j_jump");
    // addi then illegal opcode
    cyc(0, 1, OP_ADDI, F_ADD, E_FETCH_RDY, "addi_fetch");
    cyc(0, 1, OP_ADDI, F_ADD, E_DECODE,    "addi_decode");
    cyc(0, 1, OP_ADDI, F_ADD, E_ADDIEX,    "addi_ex");
    cyc(0, 1, OP_ADDI, F_ADD, E_ADDIWB,    "addi_wb");
    cyc(0, 1, OP_BAD, F_ADD, E_FETCH_RDY,  "ill_fetch");
    cyc(0, 1, OP_BAD, F_ADD, E_DEC_ILL,    "ill_decode");
    // FETCH stalled five cycles, then R-type or
    for (int i = 0; i < 5; i++)
      cyc(0, 0, OP_R, F_OR, E_FETCH_WAIT, $sformatf("fetch_wait%0d", i));
    cyc(0, 1, OP_R, F_OR, E_FETCH_RDY,   "or_fetch");
    cyc(0, 1, OP_R, F_OR, E_DECODE,      "or_decode");
    cyc(0, 1, OP_R, F_OR, E_EXEC_OR,     "or_exec");
    cyc(0, 1, OP_R, F_OR, E_RWB,         "or_rwb");
    // slt and an unknown funct (executes as AND)
    cyc(0, 1, OP_R, F_SLT, E_FETCH_RDY,  "slt_fetch");
    cyc(0, 1, OP_R, F_SLT, E_DECODE,     "slt_decode");
    cyc(0, 1, OP_R, F_SLT, E_EXEC_SLT,   "slt_exec");
    cyc(0, 1, OP_R, F_SLT, E_RWB,        "slt_rwb");
    cyc(0, 1, OP_R, F_BAD, E_FETCH_RDY,  "unk_fetch");
    cyc(0, 1, OP_R, F_BAD, E_DECODE,     "unk_decode");
    cyc(0, 1, OP_R, F_BAD, E_EXEC_UNK,   "unk_exec");
    cyc(0, 1, OP_R, F_BAD, E_RWB,        "unk_rwb");
    // sw with two wait cycles in MEMWR
    cyc(0, 1, OP_SW, F_ADD, E_FETCH_RDY,  "sw2_fetch");
    cyc(0, 1, OP_SW, F_ADD, E_DECODE,     "sw2_decode");
    cyc(0, 1, OP_SW, F_ADD, E_MEMADR,     "sw2_memadr");
    cyc(0, 0, OP_SW, F_ADD, E_MEMWR_WAIT, "sw2_wait1");
    cyc(0, 0, OP_SW, F_ADD, E_MEMWR_WAIT, "sw2_wait2");
    cyc(0, 1, OP_SW, F_ADD, E_MEMWR_RDY,  "sw2_memwr");
    // Reset while a store is pending abandons it
    cyc(0, 1, OP_SW, F_ADD, E_FETCH_RDY,  "sw3_fetch");
    cyc(0, 1, OP_SW, F_ADD, E_DECODE,     "sw3_decode");
    cyc(0, 1, OP_SW, F_ADD, E_MEMADR,     "sw3_memadr");
    cyc(0, 0, OP_SW, F_ADD, E_MEMWR_WAIT, "sw3_wait");
    cyc(1, 1, OP_SW, F_ADD, E_ZERO,       "sw3_rst");
    cyc(0, 1, OP_J, F_ADD, E_FETCH_RDY,   "post_rst_fetch");
    cyc(0, 1, OP_J, F_ADD, E_DECODE,      "post_rst_decode");
    cyc(0, 1, OP_J, F_ADD, E_JUMP,        "post_rst_jump");
    repeat (3) @(posedge clk);
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
